simon_autoplayer: RTL and testbench

- Automated player for the Simon Says game, on the opposite end of its LED/button interface: watches the game's `leds` output, captures the displayed sequence, then replays it as one-hot button presses.
- Reports pass/fail from the game's `correctLED`/`wrongLED`.
- Used for board self-test and as a closed-loop bench driver; its `buttons` output feeds the game's button inputs.

---
 rtl/simon_autoplayer.sv | 190 +++++++++++++++++++
 tb/tb_simon_autoplayer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/simon_autoplayer.sv
// Simon Says autoplayer: watches the game's LEDs, captures SEQ_LEN symbols and replays them as one-hot presses.
// Optional macro SIMON_AUTOPLAYER_CORRUPT_EN adds inject_en/inject_idx to corrupt one replayed symbol.
module simon_autoplayer #(
  parameter int SEQ_LEN        = 5,
  parameter int HOLD_CYCLES    = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int STEP_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [3:0]                         leds,
  input  logic                               correct_led,
  input  logic                               wrong_led,
`ifdef SIMON_AUTOPLAYER_CORRUPT_EN
  input  logic                               inject_en,
  input  logic [2:0]                         inject_idx,
`endif
  output logic [3:0]                         buttons,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic                               fail,
  output logic [$clog2(SEQ_LEN+1)-1:0]       captured_count
);
  localparam int CW = $clog2(SEQ_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(STEP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, KICK, CAPTURE, PRESS, GAP, WAIT_RESULT, DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [SW-1:0] step;
  logic [3:0]    prev;
  logic [2:0]    idx;
  logic [1:0]    mem [SEQ_LEN];

  logic          corrupt_on;
  logic [2:0]    corrupt_idx;
  logic [1:0]    cur_sym, first_sym, nxt_sym;
  logic [2:0]    wr_idx, nxt_idx;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  function automatic logic [1:0] encode(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] press_of(input logic [1:0] sym, input logic bump);
    logic [1:0] s;
    s = sym + {1'b0, bump};
    return 4'b0001 << s;
  endfunction

`ifdef SIMON_AUTOPLAYER_CORRUPT_EN
  // Corruption request is latched only when a game is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      corrupt_on  <= 1'b0;
      corrupt_idx <= 3'd0;
    end else if (start && (state == IDLE || state == DONE)) begin
      corrupt_on  <= inject_en;
      corrupt_idx <= inject_idx;
    end
  end
`else
  assign corrupt_on  = 1'b0;
  assign corrupt_idx = 3'd0;
`endif

  // With SEQ_LEN==1 the first replayed symbol is the one being captured right now.
  always_comb begin
    cur_sym   = encode(leds);
    wr_idx    = 3'(captured_count);
    nxt_idx   = idx + 3'd1;
    first_sym = (SEQ_LEN == 1) ? cur_sym : mem[0];
    nxt_sym   = mem[nxt_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      timer          <= '0;
      step           <= '0;
      prev           <= 4'b0000;
      idx            <= 3'd0;
      buttons        <= 4'b0000;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail           <= 1'b0;
      captured_count <= '0;
    end else begin
      done  <= 1'b0;
      timer <= timer + 1'b1;
      case (state)
        IDLE, DONE: begin
          timer <= '0;
          if (start) begin
            state          <= KICK;
            busy           <= 1'b1;
            pass           <= 1'b0;
            fail           <= 1'b0;
            captured_count <= '0;
            idx            <= 3'd0;
            buttons        <= 4'b0001;
          end
        end
        KICK: begin
          if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            fail <= 1'b1; buttons <= 4'b0000; busy <= 1'b0; done <= 1'b1; state <= DONE;
          end else if (timer == TW'(HOLD_CYCLES - 1)) begin
            buttons <= 4'b0000;
            prev    <= 4'b0000;
            step    <= '0;
            timer   <= '0;
            state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          prev <= leds;
          if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            fail <= 1'b1; busy <= 1'b0; done <= 1'b1; state <= DONE;
          end else if (leds == 4'b0000 || leds == 4'b1111) begin
            step <= '0;
          end else if (!is_onehot(leds)) begin
            fail <= 1'b1; busy <= 1'b0; done <= 1'b1; state <= DONE;
          end else if (leds != prev || step == SW'(STEP_CYCLES)) begin
            // Count restarts at 1: the capture cycle itself is the first cycle of the new symbol.
            mem[wr_idx]    <= cur_sym;
            captured_count <= captured_count + 1'b1;
            step           <= SW'(1);
            if (captured_count == CW'(SEQ_LEN - 1)) begin
              state   <= PRESS;
              timer   <= '0;
              idx     <= 3'd0;
              buttons <= press_of(first_sym, corrupt_on && (corrupt_idx == 3'd0));
            end
          end else begin
            step <= step + 1'b1;
          end
        end
        PRESS: begin
          if (wrong_led) begin
            fail <= 1'b1; buttons <= 4'b0000; busy <= 1'b0; done <= 1'b1; state <= DONE;
          end else if (timer == TW'(HOLD_CYCLES - 1)) begin
            buttons <= 4'b0000;
            timer   <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (wrong_led) begin
            fail <= 1'b1; buttons <= 4'b0000; busy <= 1'b0; done <= 1'b1; state <= DONE;
          end else if (timer == TW'(GAP_CYCLES - 1)) begin
            timer <= '0;
            if (idx < 3'(SEQ_LEN - 1)) begin
              idx     <= nxt_idx;
              buttons <= press_of(nxt_sym, corrupt_on && (corrupt_idx == nxt_idx));
              state   <= PRESS;
            end else begin
              state <= WAIT_RESULT;
            end
          end
        end
        WAIT_RESULT: begin
          if (wrong_led || timer == TW'(TIMEOUT_CYCLES - 1)) begin
            fail <= 1'b1; buttons <= 4'b0000; busy <= 1'b0; done <= 1'b1; state <= DONE;
          end else if (correct_led) begin
            pass <= 1'b1; busy <= 1'b0; done <= 1'b1; state <= DONE;
          end
        end
        default: begin
          buttons <= 4'b0000;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_simon_autoplayer.sv
// Directed self-checking bench for simon_autoplayer (SEQ_LEN=5, HOLD=2, GAP=2, STEP=3, TIMEOUT=50).
module tb_simon_autoplayer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] leds = 4'b0000;
  logic       correct_led = 1'b0;
  logic       wrong_led = 1'b0;
`ifdef SIMON_AUTOPLAYER_CORRUPT_EN
  logic       inject_en = 1'b0;
  logic [2:0] inject_idx = 3'd0;
`endif
  logic [3:0] buttons;
  logic       busy, done, pass, fail;
  logic [2:0] captured_count;

  int total = 0;
  int bad = 0;
  int rise_cnt, rel_cnt, done_cnt;
  logic [3:0] last_btn;
  logic [3:0] btn_log[$];
  logic [3:0] press_pat[$];
  int press_len[$];
  int gap_len[$];

  simon_autoplayer #(.SEQ_LEN(5), .HOLD_CYCLES(2), .GAP_CYCLES(2), .STEP_CYCLES(3), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .start(start), .leds(leds),
    .correct_led(correct_led), .wrong_led(wrong_led),
`ifdef SIMON_AUTOPLAYER_CORRUPT_EN
    .inject_en(inject_en), .inject_idx(inject_idx),
`endif
    .buttons(buttons), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .captured_count(captured_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
    if (last_btn == 4'b0000 && buttons != 4'b0000) rise_cnt++;
    if (last_btn != 4'b0000 && buttons == 4'b0000) rel_cnt++;
    last_btn = buttons;
    btn_log.push_back(buttons);
    if (done === 1'b1) done_cnt++;
  endtask

  // Leaves the DUT in CAPTURE: one start edge plus two KICK hold edges.
  task automatic start_game();
    btn_log.delete();
    rise_cnt = 0; rel_cnt = 0; done_cnt = 0; last_btn = 4'b0000;
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
  endtask

  task automatic show(input logic [3:0] v, input int n);
    leds = v;
    repeat (n) tick();
  endtask

  // Splits the button log into press runs and the zero gaps between presses.
  task automatic analyze();
    logic [3:0] cur;
    int run;
    press_pat.delete(); press_len.delete(); gap_len.delete();
    cur = 4'b0000; run = 0;
    foreach (btn_log[i]) begin
      if (btn_log[i] == cur) run++;
      else begin
        if (cur != 4'b0000) begin press_pat.push_back(cur); press_len.push_back(run); end
        else if (press_pat.size() > 0) gap_len.push_back(run);
        cur = btn_log[i]; run = 1;
      end
    end
    if (cur != 4'b0000) begin press_pat.push_back(cur); press_len.push_back(run); end
  endtask

  task automatic finish_game();
    leds = 4'b0000;
    for (int i = 0; i < 80 && done_cnt == 0; i++) begin
      if (rel_cnt >= 6) correct_led = 1'b1;
      tick();
    end
    correct_led = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; repeat (2) tick(); reset = 1'b0; tick();
    total++; if ({buttons, busy, done, pass, fail, captured_count} !== 11'd0) begin
      bad++; $display("FAIL reset_state: got %b want 0", {buttons, busy, done, pass, fail, captured_count}); end
  endtask

  task automatic test_full_game();
    logic [3:0] exp_pat [6] = '{4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b1000};
    start_game();
    total++; if (btn_log[0] !== 4'b0001 || btn_log[2] !== 4'b0000) begin
      bad++; $display("FAIL kick: got %b/%b want 0001/0000", btn_log[0], btn_log[2]); end
    show(4'b0001, 3); show(4'b0010, 3); show(4'b0001, 3); show(4'b0100, 3); show(4'b1000, 3);
    finish_game();
    analyze();
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL full_done_pulses: got %0d want 1", done_cnt); end
    total++; if (pass !== 1'b1 || fail !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL full_result: pass=%b fail=%b busy=%b want 1 0 0", pass, fail, busy); end
    total++; if (captured_count !== 3'd5) begin bad++; $display("FAIL full_count: got %0d want 5", captured_count); end
    total++; if (press_pat.size() !== 6) begin bad++; $display("FAIL full_npress: got %0d want 6", press_pat.size()); end
    for (int i = 0; i < 6 && i < press_pat.size(); i++) begin
      total++; if (press_pat[i] !== exp_pat[i] || press_len[i] !== 2) begin
        bad++; $display("FAIL full_press%0d: got %b len %0d want %b len 2", i, press_pat[i], press_len[i], exp_pat[i]); end
    end
    for (int i = 1; i < gap_len.size(); i++) begin
      total++; if (gap_len[i] !== 2) begin bad++; $display("FAIL full_gap%0d: got %0d want 2", i, gap_len[i]); end
    end
  endtask

  task automatic test_repeat_symbol();
    logic [3:0] exp_pat [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    start_game();
    total++; if (pass !== 1'b0 || fail !== 1'b0 || captured_count !== 3'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL restart_clear: pass=%b fail=%b cnt=%0d busy=%b want 0 0 0 1", pass, fail, captured_count, busy); end
    start = 1'b1; show(4'b0010, 1); start = 1'b0; show(4'b0010, 5);
    total++; if (captured_count !== 3'd2) begin bad++; $display("FAIL repeat_count: got %0d want 2", captured_count); end
    show(4'b0100, 3); show(4'b1000, 3); show(4'b0001, 3);
    finish_game();
    analyze();
    total++; if (press_pat.size() !== 6 || pass !== 1'b1) begin
      bad++; $display("FAIL repeat_npress: got %0d pass=%b want 6 1", press_pat.size(), pass); end
    for (int i = 0; i < 6 && i < press_pat.size(); i++) begin
      total++; if (press_pat[i] !== exp_pat[i] || press_len[i] !== 2) begin
        bad++; $display("FAIL repeat_press%0d: got %b len %0d want %b len 2", i, press_pat[i], press_len[i], exp_pat[i]); end
    end
  endtask

  task automatic test_wrong_led();
    int n;
    start_game();
    show(4'b0001, 3); show(4'b0010, 3); show(4'b0001, 3); show(4'b0100, 3); show(4'b1000, 3);
    leds = 4'b0000;
    n = 0;
    while (rise_cnt < 4 && n < 60) begin tick(); n++; end
    total++; if (rise_cnt !== 4) begin bad++; $display("FAIL wrong_reach3: rises %0d want 4", rise_cnt); end
    wrong_led = 1'b1; tick(); wrong_led = 1'b0;
    total++; if (buttons !== 4'b0000 || fail !== 1'b1 || pass !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL wrong_abort: btn=%b fail=%b pass=%b done=%b want 0000 1 0 1", buttons, fail, pass, done); end
    repeat (10) tick();
    analyze();
    total++; if (press_pat.size() !== 4) begin bad++; $display("FAIL wrong_npress: got %0d want 4", press_pat.size()); end
    total++; if (press_len.size() == 4 && press_len[3] !== 1) begin
      bad++; $display("FAIL wrong_len3: got %0d want 1", press_len[3]); end
  endtask

  task automatic test_timeout();
    int n;
    start_game();
    leds = 4'b0000;
    n = 0;
    while (fail !== 1'b1 && n < 100) begin tick(); n++; end
    total++; if (n !== 50) begin bad++; $display("FAIL timeout_cycles: got %0d want 50", n); end
    total++; if (done !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL timeout_state: done=%b pass=%b busy=%b want 1 0 0", done, pass, busy); end
  endtask

  task automatic test_bad_leds();
    start_game();
    show(4'b0001, 1);
    show(4'b1111, 1);
    total++; if (captured_count !== 3'd1) begin bad++; $display("FAIL ignore_1111: got %0d want 1", captured_count); end
    show(4'b0001, 1);
    total++; if (captured_count !== 3'd2) begin bad++; $display("FAIL recapture: got %0d want 2", captured_count); end
    show(4'b0011, 1);
    total++; if (fail !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || captured_count !== 3'd2) begin
      bad++; $display("FAIL bad_leds: fail=%b done=%b busy=%b cnt=%0d want 1 1 0 2", fail, done, busy, captured_count); end
    leds = 4'b0000;
  endtask

  task automatic test_reset_mid_press();
    start_game();
    show(4'b0001, 3); show(4'b0010, 3); show(4'b0001, 3); show(4'b0100, 3); show(4'b1000, 1);
    total++; if (buttons !== 4'b0001 || busy !== 1'b1) begin
      bad++; $display("FAIL mid_press_pre: btn=%b busy=%b want 0001 1", buttons, busy); end
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if ({buttons, busy, done, pass, fail, captured_count} !== 11'd0) begin
      bad++; $display("FAIL mid_press_reset: got %b want 0", {buttons, busy, done, pass, fail, captured_count}); end
    leds = 4'b0000; tick();
  endtask

`ifdef SIMON_AUTOPLAYER_CORRUPT_EN
  task automatic test_corrupt();
    logic [3:0] exp_pat [6] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
    inject_en = 1'b1; inject_idx = 3'd2;
    start_game();
    inject_en = 1'b0; inject_idx = 3'd0;
    show(4'b0001, 3); show(4'b0010, 3); show(4'b0001, 3); show(4'b0100, 3); show(4'b1000, 3);
    finish_game();
    analyze();
    total++; if (press_pat.size() !== 6) begin bad++; $display("FAIL corrupt_npress: got %0d want 6", press_pat.size()); end
    for (int i = 0; i < 6 && i < press_pat.size(); i++) begin
      total++; if (press_pat[i] !== exp_pat[i]) begin
        bad++; $display("FAIL corrupt_press%0d: got %b want %b", i, press_pat[i], exp_pat[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_game();
    test_repeat_symbol();
    test_wrong_led();
    test_timeout();
    test_bad_leds();
    test_reset_mid_press();
`ifdef SIMON_AUTOPLAYER_CORRUPT_EN
    test_corrupt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
